sramlike_axi_arbiter: RTL and testbench

SRAMLIKE_AXI_ARBITER -- requirements
Module: sramlike_axi_arbiter

---
 rtl/sramlike_axi_pkg.sv | 36 +++
 rtl/sramlike_axi_arbiter_rr_arbiter.sv | 33 +++
 rtl/sramlike_axi_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_sramlike_axi_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sramlike_axi_pkg.sv
// Shared types, AXI encodings and the write-strobe helper for the
// sram-like to AXI3 arbiter.
package sramlike_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_B
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  localparam logic [1:0] SIZE_BYTE   = 2'd0;
  localparam logic [1:0] SIZE_HALF   = 2'd1;
  localparam logic [1:0] SIZE_WORD   = 2'd2;
  localparam logic [2:0] AXSIZE_WORD = 3'd2;

  // Byte lanes touched by a single-beat write of the given size.
  function automatic logic [3:0] wstrb_gen(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: wstrb_gen = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb_gen = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   wstrb_gen = 4'b1111;
    endcase
  endfunction

  // AXI size encoding; the unused code 3 is treated as a word access.
  function automatic logic [2:0] axsize_gen(input logic [1:0] size);
    axsize_gen = (size == 2'd3) ? AXSIZE_WORD : {1'b0, size};
  endfunction

endpackage

// File: rtl/sramlike_axi_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first requester at or after ptr,
// wrapping at N.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          grant_valid,
  output logic [PW-1:0] grant_idx
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/sramlike_axi_arbiter.sv
// Multi-channel sram-like to AXI3 bridge: one AXI transaction at a time,
// channels granted round-robin. axi_rdata / axi_wdata are the AXI R and W
// data buses; the plain rdata / wdata names belong to the sram-like side.
module sramlike_axi_arbiter
  import sramlike_axi_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int MAX_BURST = 8,
  localparam int LEN_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  localparam int PW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  // sram-like channels
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       wr,
  input  logic [2*NUM_CH-1:0]     size,
  input  logic [32*NUM_CH-1:0]    addr,
  input  logic [32*NUM_CH-1:0]    wdata,
  input  logic [LEN_W*NUM_CH-1:0] len,
  output logic [NUM_CH-1:0]       addr_ok,
  output logic [NUM_CH-1:0]       data_ok,
  output logic [NUM_CH-1:0]       err,
  output logic [31:0]             rdata,
  // AXI read address
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI read data
  input  logic [3:0]              rid,
  input  logic [31:0]             axi_rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  // AXI write address
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI write data
  output logic [3:0]              wid,
  output logic [31:0]             axi_wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI write response
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  state_t            state;
  logic [PW-1:0]     grant;
  logic [PW-1:0]     rr_ptr;
  logic              lat_wr;
  logic [1:0]        lat_size;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [LEN_W-1:0]  lat_len;
  logic              aw_done;
  logic              w_done;

  logic              arb_valid;
  logic [PW-1:0]     arb_idx;

  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [LEN_W-1:0]  sel_len;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic aw_fin, w_fin;
  logic addr_pulse, data_pulse, err_pulse;

  // IDs are not checked on the response channels.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req         (req),
    .ptr         (rr_ptr),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // Pick the winning channel's request fields out of the packed buses.
  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_len   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_idx == PW'(c)) begin
        sel_wr    = wr[c];
        sel_size  = size[2*c +: 2];
        sel_addr  = addr[32*c +: 32];
        sel_wdata = wdata[32*c +: 32];
        sel_len   = len[LEN_W*c +: LEN_W];
      end
    end
  end

  // Valid/ready are pure state decodes, forced low while reset is held.
  assign arvalid = !rst && (state == ST_AR);
  assign rready  = !rst && (state == ST_R);
  assign awvalid = !rst && (state == ST_AW) && !aw_done;
  assign wvalid  = !rst && (state == ST_AW) && !w_done;
  assign bready  = !rst && (state == ST_B);

  assign ar_hs  = arvalid && arready;
  assign r_hs   = rready && rvalid;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bready && bvalid;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  assign addr_pulse = ar_hs || (!rst && (state == ST_AW) && aw_fin && w_fin);
  assign data_pulse = r_hs || b_hs;
  assign err_pulse  = (r_hs && (rresp != RESP_OKAY)) || (b_hs && (bresp != RESP_OKAY));

  // Route the handshake pulses to the granted channel only.
  always_comb begin
    addr_ok        = '0;
    data_ok        = '0;
    err            = '0;
    addr_ok[grant] = addr_pulse;
    data_ok[grant] = data_pulse;
    err[grant]     = err_pulse;
  end

  assign rdata     = axi_rdata;

  assign arid      = 4'(grant);
  assign araddr    = lat_addr;
  assign arlen     = 8'(lat_len);
  assign arsize    = axsize_gen(lat_size);
  assign arburst   = BURST_INCR;
  assign arlock    = '0;
  assign arcache   = '0;
  assign arprot    = '0;

  assign awid      = 4'(grant);
  assign awaddr    = lat_addr;
  assign awlen     = '0;
  assign awsize    = axsize_gen(lat_size);
  assign awburst   = BURST_INCR;
  assign awlock    = '0;
  assign awcache   = '0;
  assign awprot    = '0;

  assign wid       = 4'(grant);
  assign axi_wdata = lat_wdata;
  assign wstrb     = wstrb_gen(lat_size, lat_addr[1:0]);
  assign wlast     = 1'b1;

  // Transaction FSM: grant and latch in IDLE, then walk the AXI phases.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      lat_wr    <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_len   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant     <= arb_idx;
            rr_ptr    <= (arb_idx == PW'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
            lat_wr    <= sel_wr;
            lat_size  <= sel_size;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_len   <= sel_len;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= sel_wr ? ST_AW : ST_AR;
          end
        end
        ST_AR: if (arready) state <= ST_R;
        ST_R:  if (rvalid && rlast) state <= ST_IDLE;
        ST_AW: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if (aw_fin && w_fin) state <= ST_B;
        end
        ST_B:    if (bvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sramlike_axi_arbiter.sv
// Randomized bench for sramlike_axi_arbiter with a transaction-level model
// of the round-robin order and the AXI signalling expected per cycle.
module tb_sramlike_axi_arbiter;

  localparam int NUM_CH    = 2;
  localparam int MAX_BURST = 8;
  localparam int LEN_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       req, wr;
  logic [2*NUM_CH-1:0]     size;
  logic [32*NUM_CH-1:0]    addr, wdata;
  logic [LEN_W*NUM_CH-1:0] len;
  logic [NUM_CH-1:0]       addr_ok, data_ok, err;
  logic [31:0]             rdata;
  logic [3:0]              arid, awid, wid, rid, bid;
  logic [31:0]             araddr, awaddr, axi_rdata, axi_wdata;
  logic [7:0]              arlen, awlen;
  logic [2:0]              arsize, awsize, arprot, awprot;
  logic [1:0]              arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]              arcache, awcache, wstrb;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sramlike_axi_arbiter #(.NUM_CH(NUM_CH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .len(len),
    .addr_ok(addr_ok), .data_ok(data_ok), .err(err), .rdata(rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .axi_wdata(axi_wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int model_ptr = 0;

  // Per-channel request fields presented to the DUT.
  logic        c_wr   [NUM_CH];
  logic [1:0]  c_size [NUM_CH];
  logic [31:0] c_addr [NUM_CH];
  logic [31:0] c_wdata[NUM_CH];
  int          c_len  [NUM_CH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Lanes covered by an aligned access of 1/2/4 bytes containing the address.
  function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
    int nbytes, base;
    logic [3:0] s;
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    base   = int'(a[1:0]) / nbytes * nbytes;
    s      = '0;
    for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + nbytes);
    return s;
  endfunction

  function automatic int model_pick(input logic [NUM_CH-1:0] r);
    for (int k = 0; k < NUM_CH; k++)
      if (r[(model_ptr + k) % NUM_CH]) return (model_ptr + k) % NUM_CH;
    return 0;
  endfunction

  task automatic drive_ch(input logic [NUM_CH-1:0] reqv);
    req = reqv;
    for (int c = 0; c < NUM_CH; c++) begin
      wr[c]                  = c_wr[c];
      size[2*c +: 2]         = c_size[c];
      addr[32*c +: 32]       = c_addr[c];
      wdata[32*c +: 32]      = c_wdata[c];
      len[LEN_W*c +: LEN_W]  = LEN_W'(c_len[c]);
    end
  endtask

  task automatic randomize_ch();
    for (int c = 0; c < NUM_CH; c++) begin
      c_wr[c]    = 1'($urandom_range(1, 0));
      c_size[c]  = 2'($urandom_range(3, 0));
      c_addr[c]  = $urandom;
      c_wdata[c] = $urandom;
      c_len[c]   = $urandom_range(MAX_BURST - 1, 0);
    end
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      settle();
      check("idle_valid", {arvalid, awvalid, wvalid, rready, bready}, '0);
      check("idle_pulses", {addr_ok, data_ok, err}, '0);
      tick();
    end
  endtask

  // One full transaction: IDLE grant cycle, address phase(s), data/response.
  task automatic run_txn(input logic [NUM_CH-1:0] reqv, input int ar_wait, input int aw_wait,
                         input int w_wait, input int b_wait, input int err_beat,
                         input bit drop_req, input int max_rwait);
    int w, kmax, nwait;
    logic [NUM_CH-1:0] oh;
    logic        e_wr;
    logic [1:0]  e_size, rsp;
    logic [31:0] e_addr, e_wdata, d;
    int          e_len;
    drive_ch(reqv);
    settle();
    check("grant_cycle_valid", {arvalid, awvalid}, '0);
    check("grant_cycle_pulses", {addr_ok, data_ok, err}, '0);
    w = model_pick(reqv);
    model_ptr = (w + 1) % NUM_CH;
    oh = '0;
    oh[w] = 1'b1;
    e_wr = c_wr[w]; e_size = c_size[w]; e_addr = c_addr[w]; e_wdata = c_wdata[w]; e_len = c_len[w];
    tick();
    // Inputs changing after the grant must not disturb the transaction.
    randomize_ch();
    drive_ch(drop_req ? '0 : reqv);
    if (!e_wr) begin
      for (int k = 0; k <= ar_wait; k++) begin
        arready = (k == ar_wait);
        settle();
        check("arvalid", arvalid, 1'b1);
        check("awvalid_in_ar", awvalid, 1'b0);
        check("arid", arid, 4'(w));
        check("araddr", araddr, e_addr);
        check("arlen", arlen, 8'(e_len));
        check("arsize", arsize, (e_size == 2'd3) ? 3'd2 : {1'b0, e_size});
        check("ar_attrs", {arburst, arlock, arcache, arprot}, {2'b01, 9'd0});
        check("ar_addr_ok", addr_ok, (k == ar_wait) ? oh : '0);
        check("ar_data_ok", data_ok, '0);
        tick();
      end
      arready = 1'b0;
      for (int b = 0; b <= e_len; b++) begin
        nwait = $urandom_range(max_rwait, 0);
        for (int k = 0; k < nwait; k++) begin
          rvalid = 1'b0;
          settle();
          check("r_wait_rready", rready, 1'b1);
          check("r_wait_pulses", {addr_ok, data_ok, err}, '0);
          tick();
        end
        d   = $urandom;
        rsp = (b == err_beat) ? 2'($urandom_range(3, 1)) : 2'b00;
        rvalid = 1'b1; axi_rdata = d; rresp = rsp; rlast = (b == e_len);
        settle();
        check("r_rready", rready, 1'b1);
        check("r_data_ok", data_ok, oh);
        check("r_rdata", rdata, d);
        check("r_err", err, (rsp != 0) ? oh : '0);
        check("r_addr_ok", addr_ok, '0);
        tick();
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = '0;
    end else begin
      kmax = (aw_wait > w_wait) ? aw_wait : w_wait;
      for (int k = 0; k <= kmax; k++) begin
        awready = (k == aw_wait);
        wready  = (k == w_wait);
        settle();
        check("awvalid", awvalid, k <= aw_wait);
        check("wvalid", wvalid, k <= w_wait);
        check("arvalid_in_aw", arvalid, 1'b0);
        if (k <= aw_wait) begin
          check("awid", awid, 4'(w));
          check("awaddr", awaddr, e_addr);
          check("awlen", awlen, 8'd0);
          check("awsize", awsize, (e_size == 2'd3) ? 3'd2 : {1'b0, e_size});
          check("awburst", awburst, 2'b01);
        end
        if (k <= w_wait) begin
          check("wdata", axi_wdata, e_wdata);
          check("wstrb", wstrb, model_strb(e_size, e_addr));
          check("wlast", wlast, 1'b1);
        end
        check("aw_addr_ok", addr_ok, (k == kmax) ? oh : '0);
        check("aw_data_ok", data_ok, '0);
        tick();
      end
      awready = 1'b0; wready = 1'b0;
      rsp = (err_beat >= 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      for (int k = 0; k <= b_wait; k++) begin
        bvalid = (k == b_wait);
        bresp  = (k == b_wait) ? rsp : 2'b00;
        settle();
        check("bready", bready, 1'b1);
        check("b_data_ok", data_ok, (k == b_wait) ? oh : '0);
        check("b_err", err, ((k == b_wait) && (rsp != 0)) ? oh : '0);
        check("b_addr_ok", addr_ok, '0);
        tick();
      end
      bvalid = 1'b0; bresp = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; wr = '0; size = '0; addr = '0; wdata = '0; len = '0;
    arready = 0; rid = '0; axi_rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      c_wr[c] = 0; c_size[c] = 0; c_addr[c] = 0; c_wdata[c] = 0; c_len[c] = 0;
    end
    tick(); tick();
    settle();
    check("rst_valid", {arvalid, awvalid, wvalid, rready, bready}, '0);
    check("rst_pulses", {addr_ok, data_ok, err}, '0);
    check("rst_latched", {araddr, axi_wdata}, '0);
    check("rst_arlen", arlen, '0);
    rst = 1'b0;
    tick();
    idle_cycles(2);

    // Both channels requesting every time from rr_ptr=0: 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      randomize_ch();
      for (int c = 0; c < NUM_CH; c++) c_wr[c] = 1'b0;
      run_txn(2'b11, 0, 0, 0, 0, -1, 1'b1, 0);
    end

    // Channel 0 four-beat read at 0x1000 with a zero-wait slave.
    c_wr[0] = 0; c_size[0] = 2'd2; c_addr[0] = 32'h1000; c_len[0] = 3;
    run_txn(2'b01, 0, 0, 0, 0, -1, 1'b1, 0);
    idle_cycles(1);

    // Channel 1 halfword write, awready three cycles ahead of wready.
    c_wr[1] = 1; c_size[1] = 2'd1; c_addr[1] = 32'h2002; c_wdata[1] = 32'hABCD0000;
    run_txn(2'b10, 0, 0, 3, 1, -1, 1'b1, 0);

    // Two-beat read with an error response on the first beat only.
    c_wr[0] = 0; c_size[0] = 2'd2; c_addr[0] = 32'h3000; c_len[0] = 1;
    run_txn(2'b01, 0, 0, 0, 0, 0, 1'b1, 1);

    // Request withdrawn while arready stalls five cycles.
    c_wr[1] = 0; c_size[1] = 2'd0; c_addr[1] = 32'h4001; c_len[1] = 2;
    run_txn(2'b10, 5, 0, 0, 0, -1, 1'b1, 0);

    // Reset in the middle of a four-beat read, after beat 0.
    c_wr[0] = 0; c_size[0] = 2'd2; c_addr[0] = 32'h5000; c_len[0] = 3;
    drive_ch(2'b01);
    settle();
    tick();
    req = '0;
    arready = 1'b1;
    settle();
    check("rstmid_addr_ok", addr_ok, 2'b01);
    tick();
    arready = 1'b0;
    rvalid = 1'b1; axi_rdata = 32'h1234_5678; rlast = 1'b0;
    settle();
    check("rstmid_beat0", data_ok, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      rlast = (i == 2);
      settle();
      check("rstmid_data_ok", data_ok, '0);
      check("rstmid_valid", {arvalid, awvalid, rready, bready, addr_ok, err}, '0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    // rr_ptr cleared: both requesting must go to channel 0 again.
    randomize_ch();
    run_txn(2'b11, 1, 1, 0, 0, -1, 1'b1, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      randomize_ch();
      run_txn(NUM_CH'($urandom_range(3, 1)), $urandom_range(3, 0), $urandom_range(3, 0),
              $urandom_range(3, 0), $urandom_range(2, 0),
              ($urandom_range(3, 0) == 0) ? $urandom_range(MAX_BURST - 1, 0) : -1,
              1'($urandom_range(1, 0)), 2);
      idle_cycles($urandom_range(2, 0));
    end

    idle_cycles(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
